pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32: PC and address width.
REQ-002 Parameter RESET_VECTOR, default 0: PC value loaded on reset.
REQ-003 Parameter STEP, default 4: sequential increment in bytes, power of two, at least 2.
REQ-004 Parameter COUNT_W, default 16: redirect counter width.
REQ-005 Ports, in order:
- clock  in  1  sole clock, rising edge.
- resetActiveLow  in  1  asynchronous, active-low reset.
- enable  in  1  pipeline advance; 0 = global stall.
- fetchReady  in  1  instruction memory accepts the current request.
- redirectValid  in  1  branch/jump redirect request.
- redirectTarget  in  XLEN  redirect address.
- trapValid  in  1  trap/exception redirect request.
- trapVector  in  XLEN  trap handler address.
- programCounter  out  XLEN  current fetch address.
- fetchValid  out  1  fetch request valid.
- misalignedFault  out  1  misaligned redirect detected; held until a trap is applied.
- faultAddress  out  XLEN  offending redirect target.
- redirectCount  out  COUNT_W  number of applied redirects and traps.

Function
REQ-006 The block SHALL implement three states: IDLE (fetchValid=0), FETCH (fetchValid=1) and FAULT (fetchValid=0, misalignedFault=1).
REQ-007 A state or PC change SHALL occur only on an edge where enable=1; with enable=0, all state, the PC and the counter SHALL hold.
REQ-008 Next-PC priority with enable=1 SHALL be, highest first:
- trap (live or pending);
- redirect (live or pending);
- PC+STEP when fetchValid&&fetchReady;
- otherwise hold.
REQ-009 A live request SHALL take precedence over a pending request of the same class.
REQ-010 PC+STEP SHALL wrap modulo 2^XLEN; all-ones minus STEP+1 SHALL increment to 0.
REQ-011 Applying a trap SHALL load trapVector with its low log2(STEP) bits forced to 0, enter FETCH from any state, clear misalignedFault and clear both pending flags.
REQ-012 Applying a redirect whose low log2(STEP) bits are 0 SHALL load redirectTarget, enter FETCH from IDLE or FETCH, and clear the pending redirect.
REQ-013 A redirect with nonzero low log2(STEP) bits SHALL:
- leave the PC unchanged;
- enter FAULT;
- set faultAddress to the target;
- set misalignedFault=1 on the next cycle.
REQ-014 In FAULT, redirects (live or pending) SHALL be ignored and discarded; only a trap exits FAULT.
REQ-015 IDLE SHALL move to FETCH on the first enabled edge with no request, with the PC unchanged.
REQ-016 While fetchValid=1 and fetchReady=0, the PC SHALL stay stable unless a trap or redirect is applied. Applying one is a flush, and the old request is abandoned.
REQ-017 A redirect or trap asserted while enable=0 SHALL be latched as pending, with its address. A later request of the same class SHALL overwrite it.
REQ-018 A pending trap and a pending redirect SHALL coexist; on resume the trap wins and clears both.
REQ-019 redirectCount SHALL increment by 1 per applied trap or redirect, including misaligned redirects. It SHALL saturate at all-ones.
REQ-020 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-021 On reset assertion, asynchronously:
- programCounter=RESET_VECTOR;
- state IDLE, fetchValid=0;
- misalignedFault=0, faultAddress=0;
- redirectCount=0;
- pending flags and pending addresses cleared.
REQ-022 Reset asserted mid-operation SHALL discard all pending requests and faults immediately.
REQ-023 After reset deassertion, the first enabled edge SHALL enter FETCH with PC=RESET_VECTOR.

Structure
REQ-024 The state enum, the default XLEN and the default STEP SHALL live in the shared core package.
REQ-025 The pending-request latch for one request class, holding a flag plus an XLEN address, SHALL be a sub-module pc_redirect_latch, instantiated once for traps and once for redirects.

Verification
REQ-026 Reset, enable=1, fetchReady=1 for 4 cycles with defaults -> PC sequence 0 (IDLE), 0, 4, 8, 12; fetchValid rises on the first edge.
REQ-027 fetchReady=0 for 3 cycles in FETCH at PC=0x10 -> PC holds 0x10 and fetchValid stays 1; fetchReady=1 -> PC becomes 0x14.
REQ-028 redirectValid with target 0x102 (STEP=4) -> FAULT, faultAddress=0x102, misalignedFault=1, PC unchanged; a later redirect is ignored; trapValid with vector 0x203 -> PC=0x200, FETCH, fault cleared; redirectCount=2.
REQ-029 enable=0 while redirect 0x40 and then trap 0x80 are pulsed -> no change while stalled; enable=1 -> PC=0x80, both pending flags clear.
REQ-030 COUNT_W=2 with 5 redirects -> redirectCount reaches 3 and holds; PC=0xFFFFFFFC with fetchReady=1 -> PC wraps to 0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared core definitions for the program-counter unit.
//   - DEFAULT_XLEN / DEFAULT_STEP : default address width and sequential step
//   - pc_state_e                  : fetch-control state encoding
package pc_unit_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned DEFAULT_STEP = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // out of reset, no fetch issued yet
    ST_FETCH = 2'd1,  // fetch request valid
    ST_FAULT = 2'd2   // misaligned redirect seen, waiting for a trap
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Pending-request latch for one request class (trap or redirect).
// Captures a request raised during a stall so it can be applied on resume.
//   clk, rst_n    : clock, asynchronous active-low reset
//   capture       : store capture_addr as pending (a newer capture overwrites)
//   capture_addr  : address that goes with the request
//   clear         : drop the pending request (it was applied or discarded)
//   pend_valid    : a request is pending
//   pend_addr     : address of the pending request
module pc_redirect_latch
  import pc_unit_pkg::*;
#(
  parameter int unsigned XLEN = DEFAULT_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic [XLEN-1:0] capture_addr,
  input  logic            clear,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_addr
);

  logic            valid_d, valid_q;
  logic [XLEN-1:0] addr_d,  addr_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    valid_d = valid_q;
    addr_d  = addr_q;
    if (capture) begin
      valid_d = 1'b1;
      addr_d  = capture_addr;
    end else if (clear) begin
      valid_d = 1'b0;
      addr_d  = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign pend_valid = valid_q;
  assign pend_addr  = addr_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch addressing with branch redirects,
// trap redirects, global stall, misaligned-redirect fault and a saturating
// redirect counter. All outputs come straight from flops.
//   clock, resetActiveLow : clock, asynchronous active-low reset
//   enable                : pipeline advance (0 = stall, everything holds)
//   fetchReady            : instruction memory accepts the current request
//   redirectValid/Target  : branch/jump redirect request and address
//   trapValid/trapVector  : trap request and handler address
//   programCounter        : current fetch address
//   fetchValid            : fetch request valid (FETCH state)
//   misalignedFault       : misaligned redirect seen (FAULT state)
//   faultAddress          : target of the offending redirect
//   redirectCount         : applied traps + redirects, saturating
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     STEP         = DEFAULT_STEP,
  parameter int unsigned     COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               resetActiveLow,
  input  logic               enable,
  input  logic               fetchReady,
  input  logic               redirectValid,
  input  logic [XLEN-1:0]    redirectTarget,
  input  logic               trapValid,
  input  logic [XLEN-1:0]    trapVector,
  output logic [XLEN-1:0]    programCounter,
  output logic               fetchValid,
  output logic               misalignedFault,
  output logic [XLEN-1:0]    faultAddress,
  output logic [COUNT_W-1:0] redirectCount
);

  // STEP is a power of two, so STEP-1 selects exactly the low log2(STEP) bits.
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
  localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

  pc_state_e           state_d, state_q;
  logic [XLEN-1:0]     pc_d, pc_q;
  logic [XLEN-1:0]     fault_addr_d, fault_addr_q;
  logic [COUNT_W-1:0]  count_d, count_q;

  logic                trap_pend, redir_pend;
  logic [XLEN-1:0]     trap_pend_addr, redir_pend_addr;
  logic                trap_clear, redir_clear;
  logic                count_inc;

  // Requests raised while stalled are parked; while enabled they act directly.
  pc_redirect_latch #(.XLEN(XLEN)) u_trap_latch (
    .clk          (clock),
    .rst_n        (resetActiveLow),
    .capture      (!enable && trapValid),
    .capture_addr (trapVector),
    .clear        (trap_clear),
    .pend_valid   (trap_pend),
    .pend_addr    (trap_pend_addr)
  );

  pc_redirect_latch #(.XLEN(XLEN)) u_redir_latch (
    .clk          (clock),
    .rst_n        (resetActiveLow),
    .capture      (!enable && redirectValid),
    .capture_addr (redirectTarget),
    .clear        (redir_clear),
    .pend_valid   (redir_pend),
    .pend_addr    (redir_pend_addr)
  );

  // A live request beats a pending one of the same class.
  logic            trap_req, redir_req;
  logic [XLEN-1:0] trap_addr, redir_addr;

  assign trap_req   = trapValid || trap_pend;
  assign trap_addr  = trapValid ? trapVector : trap_pend_addr;
  assign redir_req  = redirectValid || redir_pend;
  assign redir_addr = redirectValid ? redirectTarget : redir_pend_addr;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fault_addr_d = fault_addr_q;
    count_inc    = 1'b0;
    trap_clear   = 1'b0;
    redir_clear  = 1'b0;

    if (enable) begin
      if (trap_req) begin
        // Trap flushes everything, including any redirect waiting behind it.
        pc_d        = trap_addr & ~ALIGN_MASK;
        state_d     = ST_FETCH;
        count_inc   = 1'b1;
        trap_clear  = 1'b1;
        redir_clear = 1'b1;
      end else if (redir_req) begin
        // The redirect is consumed either way; in FAULT it is simply dropped.
        redir_clear = 1'b1;
        if (state_q != ST_FAULT) begin
          count_inc = 1'b1;
          if ((redir_addr & ALIGN_MASK) == '0) begin
            pc_d    = redir_addr;
            state_d = ST_FETCH;
          end else begin
            state_d      = ST_FAULT;
            fault_addr_d = redir_addr;
          end
        end
      end else if (state_q == ST_IDLE) begin
        state_d = ST_FETCH;
      end else if (state_q == ST_FETCH && fetchReady) begin
        pc_d = pc_q + STEP_INC;  // wraps modulo 2^XLEN
      end
    end

    count_d = (count_inc && count_q != '1) ? count_q + COUNT_W'(1) : count_q;
  end

  always_ff @(posedge clock or negedge resetActiveLow) begin
    if (!resetActiveLow) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_VECTOR;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fault_addr_q <= fault_addr_d;
      count_q      <= count_d;
    end
  end

  assign programCounter  = pc_q;
  assign fetchValid      = (state_q == ST_FETCH);
  assign misalignedFault = (state_q == ST_FAULT);
  assign faultAddress    = fault_addr_q;
  assign redirectCount   = count_q;

endmodule
